// File: rtl/sr_ff_bank.sv
// Bank of WIDTH edge-triggered flip-flops with run-time SR/JK/D/T mode select,
// a configurable SR conflict policy and conflict pulse/count/sticky reporting.
module sr_ff_cell #(
   parameter logic       RST      = 1'b0,
   parameter logic [1:0] CONFLICT = 2'd0
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       s,
   input  logic       r,
   output logic       q
);
   always_ff @(posedge clock) begin
      if (clear) begin
         q <= RST;
      end else if (en) begin
         unique case (mode)
            2'd0: begin
               unique case ({s, r})
                  2'b00: q <= q;
                  2'b10: q <= 1'b1;
                  2'b01: q <= 1'b0;
                  2'b11: begin
                     unique case (CONFLICT)
                        2'd0: q <= q;
                        2'd1: q <= 1'b1;
                        2'd2: q <= 1'b0;
                        2'd3: q <= ~q;
                     endcase
                  end
               endcase
            end
            2'd1: begin
               unique case ({s, r})
                  2'b00: q <= q;
                  2'b10: q <= 1'b1;
                  2'b01: q <= 1'b0;
                  2'b11: q <= ~q;
               endcase
            end
            2'd2: q <= s;
            2'd3: q <= q ^ s;
         endcase
      end
   end
endmodule

module sr_ff_bank #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               CONFLICT  = 0,
   parameter int               CNT_W     = 8
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [WIDTH-1:0] en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] set,
   input  logic [WIDTH-1:0] reset,
   input  logic             ack,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             conflict,
   output logic [CNT_W-1:0] conflict_cnt,
   output logic             conflict_sticky
);
   if (CONFLICT < 0 || CONFLICT > 3) begin : g_bad_conflict
      $error("sr_ff_bank: CONFLICT must be 0..3");
   end
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("sr_ff_bank: WIDTH must be 1..32");
   end

   logic             detect;
   logic [CNT_W-1:0] cnt_base;
   logic [CNT_W-1:0] cnt_next;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sr_ff_cell #(
         .RST      (RESET_VAL[i]),
         .CONFLICT (2'(CONFLICT))
      ) u_cell (
         .clock (clock),
         .clear (clear),
         .en    (en[i]),
         .mode  (mode),
         .s     (set[i]),
         .r     (reset[i]),
         .q     (q[i])
      );
   end

   assign qbar   = ~q;
   assign detect = (mode == 2'd0) && |(en & set & reset);

   // ack clears first, then a same-cycle conflict counts on top of zero
   always_comb begin
      cnt_base = ack ? '0 : conflict_cnt;
      cnt_next = cnt_base;
      if (detect && !(&cnt_base)) cnt_next = cnt_base + CNT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         conflict        <= 1'b0;
         conflict_cnt    <= '0;
         conflict_sticky <= 1'b0;
      end else begin
         conflict        <= detect;
         conflict_cnt    <= cnt_next;
         conflict_sticky <= detect | (conflict_sticky & ~ack);
      end
   end
endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench: four banks (CONFLICT 0..3, RESET_VAL A5, CNT_W 3) share one stimulus.
module tb_sr_ff_bank;
   logic       clock = 1'b0;
   logic       clear;
   logic [7:0] en, set, reset;
   logic [1:0] mode;
   logic       ack;

   logic [7:0] q [4];
   logic [7:0] qbar [4];
   logic       conflict [4];
   logic [2:0] cnt [4];
   logic       sticky [4];

   int nvec = 0;
   int nerr = 0;

   always #5 clock = ~clock;

   for (genvar k = 0; k < 4; k++) begin : g_dut
      sr_ff_bank #(
         .WIDTH     (8),
         .RESET_VAL (8'hA5),
         .CONFLICT  (k),
         .CNT_W     (3)
      ) u_dut (
         .clock           (clock),
         .clear           (clear),
         .en              (en),
         .mode            (mode),
         .set             (set),
         .reset           (reset),
         .ack             (ack),
         .q               (q[k]),
         .qbar            (qbar[k]),
         .conflict        (conflict[k]),
         .conflict_cnt    (cnt[k]),
         .conflict_sticky (sticky[k])
      );
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [1:0] m, input logic [7:0] e, input logic [7:0] s,
                        input logic [7:0] r, input logic a);
      mode = m; en = e; set = s; reset = r; ack = a; clear = 1'b0;
   endtask

   task automatic test_reset();
      clear = 1'b1;
      for (int c = 0; c < 2; c++) begin
         en = 8'($urandom); set = 8'($urandom); reset = 8'($urandom);
         mode = 2'($urandom); ack = 1'($urandom);
         step();
      end
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (q[k] !== 8'hA5 || qbar[k] !== 8'h5A || conflict[k] !== 1'b0 ||
             cnt[k] !== 3'd0 || sticky[k] !== 1'b0) begin
            nerr++;
            $display("FAIL reset[%0d]: q=%h qbar=%h c=%b cnt=%0d st=%b, want A5 5A 0 0 0",
                     k, q[k], qbar[k], conflict[k], cnt[k], sticky[k]);
         end
      end
   endtask

   task automatic test_sr_basic();
      logic [7:0] exp_q [3] = '{8'h00, 8'h0F, 8'h0F};
      drive(2'd2, 8'hFF, 8'h00, 8'h00, 1'b0); step();   // D load of 00
      for (int p = 0; p < 3; p++) begin
         if (p == 1) drive(2'd0, 8'hFF, 8'h0F, 8'hF0, 1'b0);
         if (p == 2) drive(2'd0, 8'hFF, 8'h00, 8'h00, 1'b0);
         if (p > 0) step();
         for (int k = 0; k < 4; k++) begin
            nvec++;
            if (q[k] !== exp_q[p] || conflict[k] !== 1'b0) begin
               nerr++;
               $display("FAIL sr_basic[%0d,%0d]: q=%h c=%b, want %h 0",
                        p, k, q[k], conflict[k], exp_q[p]);
            end
         end
      end
   endtask

   task automatic test_conflict();
      logic [7:0] exp_q [4] = '{8'h0E, 8'h0F, 8'h0E, 8'h0F};
      drive(2'd0, 8'hFF, 8'h00, 8'h01, 1'b0); step();   // q = 0E
      drive(2'd0, 8'hFF, 8'h01, 8'h01, 1'b0); step();
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (q[k] !== exp_q[k] || conflict[k] !== 1'b1 || cnt[k] !== 3'd1 || sticky[k] !== 1'b1) begin
            nerr++;
            $display("FAIL conflict_policy[%0d]: q=%h c=%b cnt=%0d st=%b, want %h 1 1 1",
                     k, q[k], conflict[k], cnt[k], sticky[k], exp_q[k]);
         end
      end
      drive(2'd0, 8'hFF, 8'h00, 8'h00, 1'b0); step();
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (conflict[k] !== 1'b0 || cnt[k] !== 3'd1 || sticky[k] !== 1'b1) begin
            nerr++;
            $display("FAIL conflict_pulse_end[%0d]: c=%b cnt=%0d st=%b, want 0 1 1",
                     k, conflict[k], cnt[k], sticky[k]);
         end
      end
      drive(2'd0, 8'h00, 8'hFF, 8'hFF, 1'b0); step();
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (q[k] !== exp_q[k] || conflict[k] !== 1'b0 || cnt[k] !== 3'd1) begin
            nerr++;
            $display("FAIL conflict_en0[%0d]: q=%h c=%b cnt=%0d, want %h 0 1",
                     k, q[k], conflict[k], cnt[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_toggle();
      logic [7:0] exp_jk [3] = '{8'hFF, 8'h00, 8'hFF};
      // D load of 00 with ack, no conflict: sticky and count clear
      drive(2'd2, 8'hFF, 8'h00, 8'h00, 1'b1); step();
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (q[k] !== 8'h00 || cnt[k] !== 3'd0 || sticky[k] !== 1'b0) begin
            nerr++;
            $display("FAIL ack_clear[%0d]: q=%h cnt=%0d st=%b, want 00 0 0",
                     k, q[k], cnt[k], sticky[k]);
         end
      end
      drive(2'd1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
      for (int p = 0; p < 3; p++) begin
         step();
         for (int k = 0; k < 4; k++) begin
            nvec++;
            if (q[k] !== exp_jk[p] || conflict[k] !== 1'b0 || cnt[k] !== 3'd0) begin
               nerr++;
               $display("FAIL jk_toggle[%0d,%0d]: q=%h c=%b cnt=%0d, want %h 0 0",
                        p, k, q[k], conflict[k], cnt[k], exp_jk[p]);
            end
         end
      end
      drive(2'd2, 8'hFF, 8'h00, 8'h00, 1'b0); step();
      drive(2'd3, 8'hFF, 8'h55, 8'hFF, 1'b0);
      for (int p = 0; p < 2; p++) begin
         step();
         for (int k = 0; k < 4; k++) begin
            nvec++;
            if (q[k] !== (p == 0 ? 8'h55 : 8'h00) || conflict[k] !== 1'b0) begin
               nerr++;
               $display("FAIL t_toggle[%0d,%0d]: q=%h c=%b, want %h 0",
                        p, k, q[k], conflict[k], (p == 0 ? 8'h55 : 8'h00));
            end
         end
      end
   endtask

   task automatic test_saturation();
      drive(2'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         step();
         for (int k = 0; k < 4; k++) begin
            nvec++;
            if (cnt[k] !== 3'(i > 7 ? 7 : i) || sticky[k] !== 1'b1 || conflict[k] !== 1'b1) begin
               nerr++;
               $display("FAIL saturate[%0d,%0d]: cnt=%0d st=%b c=%b, want %0d 1 1",
                        i, k, cnt[k], sticky[k], conflict[k], (i > 7 ? 7 : i));
            end
         end
      end
      drive(2'd0, 8'hFF, 8'h00, 8'h00, 1'b1); step();
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (cnt[k] !== 3'd0 || sticky[k] !== 1'b0 || conflict[k] !== 1'b0) begin
            nerr++;
            $display("FAIL ack_only[%0d]: cnt=%0d st=%b c=%b, want 0 0 0",
                     k, cnt[k], sticky[k], conflict[k]);
         end
      end
      drive(2'd0, 8'h01, 8'h01, 8'h01, 1'b1); step();
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (cnt[k] !== 3'd1 || sticky[k] !== 1'b1 || conflict[k] !== 1'b1) begin
            nerr++;
            $display("FAIL ack_and_conflict[%0d]: cnt=%0d st=%b c=%b, want 1 1 1",
                     k, cnt[k], sticky[k], conflict[k]);
         end
      end
      drive(2'd0, 8'hFF, 8'h00, 8'h00, 1'b0); step();
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (cnt[k] !== 3'd1 || sticky[k] !== 1'b1 || conflict[k] !== 1'b0) begin
            nerr++;
            $display("FAIL post_ack_hold[%0d]: cnt=%0d st=%b c=%b, want 1 1 0",
                     k, cnt[k], sticky[k], conflict[k]);
         end
      end
   endtask

   task automatic test_enable_d();
      drive(2'd2, 8'hFF, 8'h00, 8'h00, 1'b0); step();
      drive(2'd2, 8'h0F, 8'hFF, 8'h00, 1'b0); step();
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (q[k] !== 8'h0F || qbar[k] !== 8'hF0) begin
            nerr++;
            $display("FAIL d_enable[%0d]: q=%h qbar=%h, want 0F F0", k, q[k], qbar[k]);
         end
      end
      drive(2'd0, 8'hFF, 8'h01, 8'h01, 1'b0); clear = 1'b1; step();
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (q[k] !== 8'hA5 || conflict[k] !== 1'b0 || cnt[k] !== 3'd0 || sticky[k] !== 1'b0) begin
            nerr++;
            $display("FAIL clear_override[%0d]: q=%h c=%b cnt=%0d st=%b, want A5 0 0 0",
                     k, q[k], conflict[k], cnt[k], sticky[k]);
         end
      end
      drive(2'd2, 8'h00, 8'h00, 8'h00, 1'b0); step();
      for (int k = 0; k < 4; k++) begin
         nvec++;
         if (q[k] !== 8'hA5) begin
            nerr++;
            $display("FAIL post_clear_hold[%0d]: q=%h, want A5", k, q[k]);
         end
      end
   endtask

   initial begin
      clear = 1'b1; en = '0; set = '0; reset = '0; mode = '0; ack = 1'b0;
      @(negedge clock);
      test_reset();
      test_sr_basic();
      test_conflict();
      test_toggle();
      test_saturation();
      test_enable_d();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
